// File: rtl/vad_decision.sv
// vad_decision: pairs per-window STE/ZCR flags into frame observations and
// debounces them with an onset/hangover hysteresis state machine into a
// speech flag, start/end event pulses and a saturating segment length.
module vad_decision #(
    parameter int unsigned ONSET_FRAMES = 3,
    parameter int unsigned HANG_FRAMES  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ste,
    input  logic        ste_valid,
    input  logic        zcr,
    input  logic        zcr_valid,
    output logic        vad,
    output logic        vad_valid,
    output logic        speech_start,
    output logic        speech_end,
    output logic [15:0] seg_len,
    output logic        overrun
);

    typedef enum logic [1:0] {
        SILENCE,
        ONSET,
        SPEECH,
        HANGOVER
    } state_t;

    localparam logic [7:0]  ONSET_N   = 8'(ONSET_FRAMES);
    localparam logic [7:0]  HANG_N    = 8'(HANG_FRAMES);
    localparam logic [15:0] SEG_START = 16'(ONSET_FRAMES);

    state_t      state;
    logic [7:0]  cnt;
    logic        ste_p, ste_h;
    logic        zcr_p, zcr_h;

    logic        eval;
    logic        ste_eff, zcr_eff;
    logic        act;
    logic [15:0] seg_inc;

    // A strobe on the evaluation edge counts as pending, and its live value
    // takes precedence over the held one.
    assign eval    = (ste_p | ste_valid) & (zcr_p | zcr_valid);
    assign ste_eff = ste_valid ? ste : ste_h;
    assign zcr_eff = zcr_valid ? zcr : zcr_h;
    // Energetic frames are voiced; quiet but high-crossing frames are unvoiced speech.
    assign act     = ~ste_eff | zcr_eff;
    assign seg_inc = (seg_len == 16'hFFFF) ? seg_len : seg_len + 16'd1;

    // Pending/held registers for each flag, plus the sticky overrun flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ste_p   <= 1'b0;
            ste_h   <= 1'b0;
            zcr_p   <= 1'b0;
            zcr_h   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= so every register samples the pre-edge values.
            if (eval) begin
                ste_p <= 1'b0;
                zcr_p <= 1'b0;
            end else begin
                if (ste_valid) begin
                    ste_p <= 1'b1;
                    ste_h <= ste;
                end
                if (zcr_valid) begin
                    zcr_p <= 1'b1;
                    zcr_h <= zcr;
                end
            end
            // Without eval, a re-strobe on a pending side means the other side is idle.
            if (!eval && ((ste_valid && ste_p) || (zcr_valid && zcr_p))) begin
                overrun <= 1'b1;
            end
        end
    end

    // Hysteresis FSM with registered vad, event pulses and segment length.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= SILENCE;
            cnt          <= 8'd0;
            vad          <= 1'b0;
            vad_valid    <= 1'b0;
            speech_start <= 1'b0;
            speech_end   <= 1'b0;
            seg_len      <= 16'd0;
        end else begin
            vad_valid    <= eval;
            speech_start <= 1'b0;
            speech_end   <= 1'b0;
            if (eval) begin
                case (state)
                    SILENCE: begin
                        if (act) begin
                            if (ONSET_N == 8'd1) begin
                                state        <= SPEECH;
                                vad          <= 1'b1;
                                speech_start <= 1'b1;
                                seg_len      <= SEG_START;
                                cnt          <= 8'd0;
                            end else begin
                                state <= ONSET;
                                cnt   <= 8'd1;
                            end
                        end
                    end
                    ONSET: begin
                        if (act) begin
                            if (cnt + 8'd1 == ONSET_N) begin
                                state        <= SPEECH;
                                vad          <= 1'b1;
                                speech_start <= 1'b1;
                                seg_len      <= SEG_START;
                                cnt          <= 8'd0;
                            end else begin
                                cnt <= cnt + 8'd1;
                            end
                        end else begin
                            state <= SILENCE;
                            cnt   <= 8'd0;
                        end
                    end
                    SPEECH: begin
                        seg_len <= seg_inc;
                        if (!act) begin
                            if (HANG_N == 8'd1) begin
                                state      <= SILENCE;
                                vad        <= 1'b0;
                                speech_end <= 1'b1;
                                cnt        <= 8'd0;
                            end else begin
                                state <= HANGOVER;
                                cnt   <= 8'd1;
                            end
                        end
                    end
                    HANGOVER: begin
                        seg_len <= seg_inc;
                        if (act) begin
                            state <= SPEECH;
                            cnt   <= 8'd0;
                        end else if (cnt + 8'd1 == HANG_N) begin
                            state      <= SILENCE;
                            vad        <= 1'b0;
                            speech_end <= 1'b1;
                            cnt        <= 8'd0;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    default: begin
                        state <= SILENCE;
                        cnt   <= 8'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vad_decision.sv
// tb_vad_decision: directed-vector bench for vad_decision. One instance uses
// the default parameters, a second uses ONSET_FRAMES=1 / HANG_FRAMES=1.
module tb_vad_decision;

    logic        clk;
    logic        reset;

    logic        a_ste, a_ste_valid, a_zcr, a_zcr_valid;
    logic        a_vad, a_vad_valid, a_start, a_end, a_overrun;
    logic [15:0] a_seg_len;

    logic        b_ste, b_ste_valid, b_zcr, b_zcr_valid;
    logic        b_vad, b_vad_valid, b_start, b_end, b_overrun;
    logic [15:0] b_seg_len;

    int n_checks = 0;
    int n_errors = 0;

    vad_decision dut (
        .clk          (clk),
        .reset        (reset),
        .ste          (a_ste),
        .ste_valid    (a_ste_valid),
        .zcr          (a_zcr),
        .zcr_valid    (a_zcr_valid),
        .vad          (a_vad),
        .vad_valid    (a_vad_valid),
        .speech_start (a_start),
        .speech_end   (a_end),
        .seg_len      (a_seg_len),
        .overrun      (a_overrun)
    );

    vad_decision #(.ONSET_FRAMES(1), .HANG_FRAMES(1)) dut1 (
        .clk          (clk),
        .reset        (reset),
        .ste          (b_ste),
        .ste_valid    (b_ste_valid),
        .zcr          (b_zcr),
        .zcr_valid    (b_zcr_valid),
        .vad          (b_vad),
        .vad_valid    (b_vad_valid),
        .speech_start (b_start),
        .speech_end   (b_end),
        .seg_len      (b_seg_len),
        .overrun      (b_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Drive strobes at the falling edge, let one rising edge pass, then drop
    // the strobes 1 time unit later; outputs are sampled right after.
    task automatic step(input int which, input logic sv, input logic s,
                        input logic zv, input logic z);
        @(negedge clk);
        if (which == 0) begin
            a_ste_valid = sv; a_ste = s; a_zcr_valid = zv; a_zcr = z;
        end else begin
            b_ste_valid = sv; b_ste = s; b_zcr_valid = zv; b_zcr = z;
        end
        @(posedge clk);
        #1;
        a_ste_valid = 1'b0; a_zcr_valid = 1'b0;
        b_ste_valid = 1'b0; b_zcr_valid = 1'b0;
    endtask

    task automatic frame(input int which, input logic s, input logic z);
        step(which, 1'b1, s, 1'b1, z);
    endtask

    task automatic idle(input int which);
        step(which, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        a_ste = 0; a_ste_valid = 0; a_zcr = 0; a_zcr_valid = 0;
        b_ste = 0; b_ste_valid = 0; b_zcr = 0; b_zcr_valid = 0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_vad", a_vad, 0);
        check("rst_vad_valid", a_vad_valid, 0);
        check("rst_seg_len", a_seg_len, 0);
        check("rst_overrun", a_overrun, 0);
        check("rst_start", a_start, 0);
        @(negedge clk);
        reset = 1'b1;

        // Onset aborted by a quiet frame after two active frames.
        frame(0, 0, 0);
        check("onset1_valid", a_vad_valid, 1);
        check("onset1_vad", a_vad, 0);
        frame(0, 0, 0);
        check("onset2_vad", a_vad, 0);
        frame(0, 1, 0);
        check("abort_vad", a_vad, 0);
        check("abort_start", a_start, 0);
        frame(0, 0, 0);
        check("re1_vad", a_vad, 0);
        frame(0, 0, 0);
        check("re2_vad", a_vad, 0);
        check("re2_start", a_start, 0);
        frame(0, 0, 0);
        check("re3_vad", a_vad, 1);
        check("re3_start", a_start, 1);
        check("re3_seg_len", a_seg_len, 3);
        idle(0);
        check("start_pulse_1cy", a_start, 0);
        check("idle_vad_valid", a_vad_valid, 0);

        // Hangover: 7 quiet, 1 unvoiced-active, 8 quiet.
        for (int i = 0; i < 7; i++) begin
            frame(0, 1, 0);
            check($sformatf("hang_a%0d_vad", i), a_vad, 1);
            check($sformatf("hang_a%0d_end", i), a_end, 0);
        end
        frame(0, 1, 1);
        check("hang_resume_vad", a_vad, 1);
        check("hang_resume_start", a_start, 0);
        for (int i = 0; i < 7; i++) begin
            frame(0, 1, 0);
            check($sformatf("hang_b%0d_vad", i), a_vad, 1);
        end
        frame(0, 1, 0);
        check("hang_end_vad", a_vad, 0);
        check("hang_end_pulse", a_end, 1);
        check("hang_end_valid", a_vad_valid, 1);
        check("hang_seg_len", a_seg_len, 19);
        idle(0);
        check("end_pulse_1cy", a_end, 0);
        check("seg_len_hold", a_seg_len, 19);

        // Staggered strobes: ste now, zcr four cycles later.
        step(0, 1, 1, 0, 0);
        check("stag_t0_valid", a_vad_valid, 0);
        for (int i = 0; i < 3; i++) begin
            idle(0);
            check($sformatf("stag_idle%0d_valid", i), a_vad_valid, 0);
        end
        step(0, 0, 0, 1, 0);
        check("stag_eval_valid", a_vad_valid, 1);
        check("stag_eval_vad", a_vad, 0);
        idle(0);
        check("stag_after_valid", a_vad_valid, 0);

        // Reset in the middle of a speech segment.
        for (int i = 0; i < 4; i++) frame(0, 0, 0);
        check("mid_vad", a_vad, 1);
        check("mid_seg_len", a_seg_len, 4);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("async_rst_vad", a_vad, 0);
        check("async_rst_seg_len", a_seg_len, 0);
        @(negedge clk);
        reset = 1'b1;
        check("rst_no_end", a_end, 0);
        idle(0);
        check("rst_no_end2", a_end, 0);
        frame(0, 1, 0);
        check("post_rst_valid", a_vad_valid, 1);
        check("post_rst_vad", a_vad, 0);
        check("no_overrun_a", a_overrun, 0);

        // Single-frame onset/hangover instance.
        frame(1, 0, 0);
        check("p1_start", b_start, 1);
        check("p1_vad", b_vad, 1);
        check("p1_seg_len", b_seg_len, 1);
        frame(1, 1, 0);
        check("p1_end", b_end, 1);
        check("p1_end_start", b_start, 0);
        check("p1_end_vad", b_vad, 0);
        check("p1_end_seg_len", b_seg_len, 2);

        // Overrun: ste quiet, then ste energetic overwrites it, then zcr.
        step(1, 1, 1, 0, 0);
        check("ovr_first", b_overrun, 0);
        idle(1);
        step(1, 1, 0, 0, 0);
        check("ovr_set", b_overrun, 1);
        check("ovr_no_eval", b_vad_valid, 0);
        idle(1);
        idle(1);
        step(1, 0, 0, 1, 0);
        check("ovr_eval_valid", b_vad_valid, 1);
        check("ovr_uses_new_ste", b_start, 1);
        check("ovr_vad", b_vad, 1);
        check("ovr_sticky", b_overrun, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vad_decision.md
# vad_decision

Frame-level voice-activity decision stage that sits directly downstream of the short-time-energy and zero-crossing-rate detectors in the audio front end. It pairs the per-window `ste` and `zcr` flags into one frame observation. A hysteresis state machine with onset and hangover counters turns those observations into a debounced `vad` flag, plus start/end event pulses for the keyword/recording logic further on.

## Interface
- `ONSET_FRAMES`, 3: consecutive active frames required to declare speech; legal 1..255.
- `HANG_FRAMES`, 8: consecutive inactive frames required to end speech; legal 1..255.
- `clk` input 1: single clock; all logic rises on posedge.
- `reset` input 1: asynchronous, active-low reset (asserted when 0).
- `ste` input 1: energy flag from STE stage; 1 = window energy below threshold (quiet), 0 = energetic.
- `ste_valid` input 1: single-cycle strobe; `ste` is sampled when high.
- `zcr` input 1: zero-crossing flag; 1 = crossing count above threshold (unvoiced/fricative).
- `zcr_valid` input 1: single-cycle strobe; `zcr` is sampled when high.
- `vad` output 1: debounced speech flag.
- `vad_valid` output 1: one-cycle pulse per evaluated frame.
- `speech_start` output 1: one-cycle pulse on entry to SPEECH.
- `speech_end` output 1: one-cycle pulse on return to SILENCE from HANGOVER.
- `seg_len` output 16: frames counted in the current/last speech segment, saturating at 0xFFFF.
- `overrun` output 1: sticky; a strobe arrived while its flag was still unpaired.

## Operation
- Pairing: two pending registers, `ste_p`/`zcr_p`, each with a held value.
  - A strobe sets its pending bit and stores its flag.
  - A frame is evaluated on the edge where both are pending, counting a strobe arriving on that same edge. Both pending bits clear on that edge.
- Overrun: a strobe arrives while its own pending bit is set and the other side is neither pending nor strobing.
  - The new value overwrites the old one.
  - `overrun` sets to 1 and clears only on reset.
- Frame activity: `act = ~ste_held | zcr_held`. Energetic frames are voiced; quiet frames with a high crossing rate are unvoiced speech.
- States: SILENCE, ONSET, SPEECH, HANGOVER. One 8-bit counter `cnt`. Transitions happen only on evaluation edges:
  - SILENCE, act: go to SPEECH with `speech_start` if ONSET_FRAMES=1; else go to ONSET with cnt=1. SILENCE, !act: stay.
  - ONSET, act: cnt+1. When cnt+1 = ONSET_FRAMES, go to SPEECH, pulse `speech_start`, cnt=0. ONSET, !act: go to SILENCE, cnt=0.
  - SPEECH, act: stay. SPEECH, !act: go to SILENCE with `speech_end` if HANG_FRAMES=1; else go to HANGOVER with cnt=1.
  - HANGOVER, act: go to SPEECH, cnt=0, no pulses. HANGOVER, !act: cnt+1. When cnt+1 = HANG_FRAMES, go to SILENCE, pulse `speech_end`, cnt=0.
- `vad` = 1 in SPEECH and HANGOVER, 0 in SILENCE and ONSET.
- `seg_len`:
  - Loads ONSET_FRAMES on the `speech_start` edge.
  - Increments on every later evaluation while in SPEECH/HANGOVER, including the `speech_end` frame, saturating at 0xFFFF.
  - Holds its value through SILENCE until the next start.

## Timing
- Reset (`reset`=0) forces state SILENCE, cnt=0, both pending bits 0, and every output 0, immediately and asynchronously. This includes reset mid-segment: no `speech_end` is produced.
- Latency: the evaluation edge is the first posedge on which the later of the two strobes is high.
  - `vad_valid`, `vad`, `speech_start`, `speech_end` and `seg_len` are registered and show the new values in the cycle after that edge.
  - `vad_valid`, `speech_start` and `speech_end` are high for exactly one cycle.
- Simultaneous `ste_valid` and `zcr_valid` with nothing pending: evaluated on that edge.
- Strobes back-to-back on consecutive cycles are each accepted. There is no throughput limit beyond one frame per cycle.
- `speech_start` and `speech_end` never assert on the same cycle.
- `vad` changes only in a cycle where `vad_valid`=1.

## Test plan
- Reset mid-SPEECH: `reset` low for 1 cycle -> `vad`=0, `seg_len`=0, no `speech_end` pulse. A following quiet frame gives `vad_valid`=1, `vad`=0.
- Onset with defaults: frames (ste,zcr) = (0,0) ×3, strobes simultaneous -> `vad` stays 0 through frame 2. After frame 3, `vad`=1 with a `speech_start` pulse and `seg_len`=3. An intervening (1,0) after 2 active frames returns to SILENCE, and 3 more active frames are then required.
- Hangover: in SPEECH, 7 quiet (1,0) frames, then (1,1), then 8 quiet frames -> `vad` stays 1 throughout the first 7 and the return to SPEECH. On the 8th quiet frame, `speech_end` pulses and `vad`=0. `seg_len` = 3 + 16 = 19.
- Staggered strobes: `ste_valid` at cycle 10, `zcr_valid` at cycle 14 -> exactly one `vad_valid`, in cycle 15.
- Overrun: `ste_valid` at cycles 10 and 12, `zcr_valid` at 15 -> `overrun`=1 from cycle 13. One evaluation uses the `ste` value from cycle 12.
- Parameters ONSET_FRAMES=1 and HANG_FRAMES=1: a single active frame gives `speech_start` and `vad`=1; the next single quiet frame gives `speech_end` and `vad`=0, with `seg_len`=2.
